// File: rtl/add16_arbiter_if.sv
// Operand/result bus for add16_arbiter: two requesters, one consumer.
// Carries req0/req1 valid-ready-operands, rsp valid-ready-result and ovf_count.
interface add16_arbiter_if;
  logic        req0_valid;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_sum;
  logic        rsp_carry;
  logic        rsp_id;
  logic [7:0]  ovf_count;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_sum, rsp_carry, rsp_id,
    input  rsp_ready,
    output ovf_count
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_sum, rsp_carry, rsp_id,
    output rsp_ready,
    input  ovf_count
  );
endinterface

// File: rtl/add16_arbiter.sv
// Round-robin 2:1 arbiter feeding a registered 16-bit adder stage.
// Ports: clk, rst_n (async active-low), bus (add16_arbiter_if.slave).
module add16_arbiter (
  input  logic            clk,
  input  logic            rst_n,
  add16_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, HOLD} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_valid;
  logic [15:0] r_sum;
  logic        r_carry;
  logic        r_id;
  logic [7:0]  r_ovf;

  logic        w_open;
  logic        w_g0;
  logic        w_g1;
  logic        w_hs0;
  logic        w_hs1;
  logic        w_hs;
  logic        w_rsp_hs;
  logic [16:0] w_sum0;
  logic [16:0] w_sum1;

  // Window gated by rst_n so both readys stay low while in reset.
  assign w_open = rst_n &
                  ((r_state == IDLE) | bus.rsp_ready);

  // Under contention the requester not granted last wins.
  assign w_g0 = bus.req0_valid &
                (~bus.req1_valid | r_last);
  assign w_g1 = bus.req1_valid &
                (~bus.req0_valid | ~r_last);

  assign bus.req0_ready = w_open & w_g0;
  assign bus.req1_ready = w_open & w_g1;

  assign w_hs0 = bus.req0_valid & bus.req0_ready;
  assign w_hs1 = bus.req1_valid & bus.req1_ready;
  assign w_hs  = w_hs0 | w_hs1;

  assign w_rsp_hs = r_valid & bus.rsp_ready;

  assign w_sum0 = {1'b0, bus.req0_a} +
                  {1'b0, bus.req0_b};
  assign w_sum1 = {1'b0, bus.req1_a} +
                  {1'b0, bus.req1_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_valid <= 1'b0;
      r_sum   <= 16'h0000;
      r_carry <= 1'b0;
      r_id    <= 1'b0;
      r_ovf   <= 8'h00;
    end else begin
      if (w_rsp_hs && r_carry && (r_ovf != 8'hFF))
        r_ovf <= r_ovf + 8'd1;
      unique case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (w_hs) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
          end else if (bus.rsp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
      if (w_hs) begin
        r_last  <= w_hs1;
        r_id    <= w_hs1;
        r_sum   <= w_hs1 ? w_sum1[15:0] :
                           w_sum0[15:0];
        r_carry <= w_hs1 ? w_sum1[16] :
                           w_sum0[16];
      end
    end
  end

  assign bus.rsp_valid = r_valid;
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_carry = r_carry;
  assign bus.rsp_id    = r_id;
  assign bus.ovf_count = r_ovf;
endmodule

// File: tb/tb_add16_arbiter.sv
// Directed table-driven bench for add16_arbiter.
// Vectors for grant/hold/contention plus reset and saturation sequences.
module tb_add16_arbiter;
  logic clk;
  logic rst_n;
  add16_arbiter_if bus ();

  add16_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        v1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        rr;
    logic        e_r0;
    logic        e_r1;
    logic        e_val;
    logic        chk_data;
    logic [15:0] e_sum;
    logic        e_c;
    logic        e_id;
    logic [7:0]  e_ovf;
  } vec_t;

  vec_t vt [16];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v0, input logic [15:0] a0,
    input logic [15:0] b0,
    input logic v1, input logic [15:0] a1,
    input logic [15:0] b1,
    input logic rr, input logic r0,
    input logic r1, input logic val,
    input logic cd, input logic [15:0] s,
    input logic c, input logic id,
    input logic [7:0] ovf);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1;
    v.rr = rr; v.e_r0 = r0; v.e_r1 = r1;
    v.e_val = val; v.chk_data = cd;
    v.e_sum = s; v.e_c = c; v.e_id = id;
    v.e_ovf = ovf;
    return v;
  endfunction

  task automatic drive(input logic v0,
                       input logic [15:0] a0,
                       input logic [15:0] b0,
                       input logic v1,
                       input logic [15:0] a1,
                       input logic [15:0] b1,
                       input logic rr);
    bus.req0_valid = v0;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req1_valid = v1;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
    bus.rsp_ready  = rr;
  endtask

  initial begin
    vt[0]  = mk(0,16'h0,16'h0,0,16'h0,16'h0,1,
                0,0,0,1,16'h0000,0,0,8'd0);
    vt[1]  = mk(1,16'h1,16'h2,0,16'h0,16'h0,0,
                1,0,1,1,16'h0003,0,0,8'd0);
    vt[2]  = mk(0,16'h0,16'h0,1,16'hFFFF,16'h1,0,
                0,0,1,1,16'h0003,0,0,8'd0);
    vt[3]  = mk(0,16'h0,16'h0,1,16'hFFFF,16'h1,1,
                0,1,1,1,16'h0000,1,1,8'd0);
    vt[4]  = mk(0,16'h0,16'h0,0,16'h0,16'h0,1,
                0,0,0,0,16'h0000,0,0,8'd1);
    vt[5]  = mk(1,16'h00F0,16'h000F,
                1,16'hAAAA,16'h5555,1,
                1,0,1,1,16'h00FF,0,0,8'd1);
    vt[6]  = mk(1,16'h00F0,16'h000F,
                1,16'hAAAA,16'h5555,1,
                0,1,1,1,16'hFFFF,0,1,8'd1);
    vt[7]  = mk(1,16'h00F0,16'h000F,
                1,16'hAAAA,16'h5555,1,
                1,0,1,1,16'h00FF,0,0,8'd1);
    vt[8]  = mk(1,16'h00F0,16'h000F,
                1,16'hAAAA,16'h5555,1,
                0,1,1,1,16'hFFFF,0,1,8'd1);
    for (int i = 9; i < 14; i++)
      vt[i] = mk(1,16'h00F0,16'h000F,
                 1,16'hAAAA,16'h5555,0,
                 0,0,1,1,16'hFFFF,0,1,8'd1);
    vt[14] = mk(1,16'h00F0,16'h000F,
                1,16'hAAAA,16'h5555,1,
                1,0,1,1,16'h00FF,0,0,8'd1);
    vt[15] = mk(0,16'h0,16'h0,0,16'h0,16'h0,1,
                0,0,0,0,16'h0000,0,0,8'd1);

    drive(0,0,0,0,0,0,0);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.rsp_valid), 0);
    chk("rst_sum",   32'(bus.rsp_sum),   0);
    chk("rst_carry", 32'(bus.rsp_carry), 0);
    chk("rst_id",    32'(bus.rsp_id),    0);
    chk("rst_ovf",   32'(bus.ovf_count), 0);
    drive(1,16'h1,16'h1,1,16'h1,16'h1,1);
    #1;
    chk("rst_r0", 32'(bus.req0_ready), 0);
    chk("rst_r1", 32'(bus.req1_ready), 0);
    drive(0,0,0,0,0,0,0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i].v0, vt[i].a0, vt[i].b0,
            vt[i].v1, vt[i].a1, vt[i].b1,
            vt[i].rr);
      #1;
      chk($sformatf("v%0d_r0", i),
          32'(bus.req0_ready), 32'(vt[i].e_r0));
      chk($sformatf("v%0d_r1", i),
          32'(bus.req1_ready), 32'(vt[i].e_r1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i),
          32'(bus.rsp_valid), 32'(vt[i].e_val));
      if (vt[i].chk_data) begin
        chk($sformatf("v%0d_sum", i),
            32'(bus.rsp_sum), 32'(vt[i].e_sum));
        chk($sformatf("v%0d_carry", i),
            32'(bus.rsp_carry), 32'(vt[i].e_c));
        chk($sformatf("v%0d_id", i),
            32'(bus.rsp_id), 32'(vt[i].e_id));
      end
      chk($sformatf("v%0d_ovf", i),
          32'(bus.ovf_count), 32'(vt[i].e_ovf));
    end

    // Reset while holding a carry result.
    @(negedge clk);
    drive(1,16'hFFFF,16'hFFFF,0,0,0,0);
    @(posedge clk);
    #1;
    chk("mid_hold_valid", 32'(bus.rsp_valid), 1);
    chk("mid_hold_sum",   32'(bus.rsp_sum), 32'hFFFE);
    @(negedge clk);
    drive(1,16'h1,16'h1,1,16'h2,16'h2,1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_ovf",   32'(bus.ovf_count), 0);
    chk("mid_rst_r0",    32'(bus.req0_ready), 0);
    chk("mid_rst_r1",    32'(bus.req1_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_r0", 32'(bus.req0_ready), 1);
    chk("post_rst_r1", 32'(bus.req1_ready), 0);
    @(posedge clk);
    #1;
    chk("post_rst_id",  32'(bus.rsp_id), 0);
    chk("post_rst_sum", 32'(bus.rsp_sum), 32'h0002);

    // Drain, then 260 back-to-back carry results.
    @(negedge clk);
    drive(0,0,0,0,0,0,1);
    @(negedge clk);
    drive(1,16'hFFFF,16'h0001,0,0,0,1);
    repeat (260) @(negedge clk);
    drive(0,0,0,0,0,0,1);
    repeat (3) @(negedge clk);
    chk("sat_valid", 32'(bus.rsp_valid), 0);
    chk("sat_ovf",   32'(bus.ovf_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
